// File: rtl/spi_slave_byte.sv
// spi_slave_byte -- mode-0 SPI responder (CPOL=0, CPHA=0, MSB first, SS active low).
// All SPI pins are oversampled in the i_clk domain. MOSI is deserialised into bytes.
// MISO is serialised from a one-deep transmit holding register.
// Optional build macro: SPI_SLAVE_MISO_OE_EN adds o_spi_miso_oe for an external tristate.
module spi_slave_byte #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_spi_sclk,
  input  logic       i_spi_ss_n,
  input  logic       i_spi_mosi,
  output logic       o_spi_miso,
`ifdef SPI_SLAVE_MISO_OE_EN
  output logic       o_spi_miso_oe,
`endif
  input  logic [7:0] i_tx_byte,
  input  logic       i_tx_valid,
  output logic       o_tx_ready,
  output logic [7:0] o_rx_byte,
  output logic       o_rx_valid,
  output logic       o_tx_underrun,
  output logic       o_busy
);

  localparam logic [0:0] ST_IDLE   = 1'b0;
  localparam logic [0:0] ST_ACTIVE = 1'b1;

  logic [SYNC_STAGES-1:0] r_sclk_sync;
  logic [SYNC_STAGES-1:0] r_ss_sync;
  logic [SYNC_STAGES-1:0] r_mosi_sync;
  logic [SYNC_STAGES-1:0] r_sync_ok;
  logic                   r_sclk_d;
  logic                   r_ss_d;
  logic                   r_armed;
  logic [0:0]             r_state;
  logic [2:0]             r_bit_cnt;
  logic [6:0]             r_rx_shift;
  logic [7:0]             r_tx_shift;
  logic [7:0]             r_rx_byte;
  logic [7:0]             r_hold;
  logic                   r_hold_full;
  logic                   r_load_pend;
  logic                   r_rx_valid;
  logic                   r_tx_underrun;

  logic       w_sclk_s;
  logic       w_ss_s;
  logic       w_mosi_s;
  logic       w_sync_ok;
  logic       w_sclk_rise;
  logic       w_sclk_fall;
  logic       w_ss_fall;
  logic       w_ss_rise;
  logic       w_active;
  logic       w_load;
  logic       w_handshake;
  logic [7:0] w_load_byte;

  assign w_sclk_s  = r_sclk_sync[SYNC_STAGES-1];
  assign w_ss_s    = r_ss_sync[SYNC_STAGES-1];
  assign w_mosi_s  = r_mosi_sync[SYNC_STAGES-1];
  assign w_sync_ok = r_sync_ok[SYNC_STAGES-1];

  assign w_sclk_rise = w_sclk_s & ~r_sclk_d;
  assign w_sclk_fall = ~w_sclk_s & r_sclk_d;
  assign w_ss_rise   = w_ss_s & ~r_ss_d;
  // A fall only counts once SS has genuinely been seen high since reset, so an SS
  // that is already low when reset is released cannot start a frame mid-transfer.
  assign w_ss_fall   = ~w_ss_s & r_ss_d & r_armed;

  assign w_active    = (r_state == ST_ACTIVE);
  assign w_handshake = i_tx_valid & ~r_hold_full;
  // Byte slots start on SS fall, and on the first SCLK fall after the bit counter wraps.
  assign w_load      = (~w_active & w_ss_fall) |
                       (w_active & ~w_ss_rise & w_sclk_fall & r_load_pend);
  assign w_load_byte = r_hold_full ? r_hold : 8'h00;

  // Input synchronisers; r_sync_ok marks when the SS chain reflects the real pin.
  // NOTE: every clocked block uses non-blocking (<=) assignments so all flops sample
  // pre-edge values; blocking assignments here would collapse the synchroniser chain.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_sclk_sync <= '0;
      r_ss_sync   <= '1;
      r_mosi_sync <= '0;
      r_sync_ok   <= '0;
    end else begin
      r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], i_spi_sclk};
      r_ss_sync   <= {r_ss_sync[SYNC_STAGES-2:0], i_spi_ss_n};
      r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], i_spi_mosi};
      r_sync_ok   <= {r_sync_ok[SYNC_STAGES-2:0], 1'b1};
    end
  end

  // Previous samples for edge detection, plus the SS-seen-high arming flag.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_sclk_d <= 1'b0;
      r_ss_d   <= 1'b1;
      r_armed  <= 1'b0;
    end else begin
      r_sclk_d <= w_sclk_s;
      r_ss_d   <= w_ss_s;
      r_armed  <= r_armed | (w_sync_ok & w_ss_s);
    end
  end

  // Transmit holding register: a slot load empties it, a handshake fills it.
  // A handshake coinciding with a load is seen only by the following slot.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_hold      <= 8'h00;
      r_hold_full <= 1'b0;
    end else if (w_load && r_hold_full) begin
      r_hold_full <= 1'b0;
    end else if (w_handshake) begin
      r_hold      <= i_tx_byte;
      r_hold_full <= 1'b1;
    end
  end

  // Frame state, bit counter, RX deserialiser and TX serialiser.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_state       <= ST_IDLE;
      r_bit_cnt     <= 3'd0;
      r_rx_shift    <= 7'd0;
      r_tx_shift    <= 8'h00;
      r_load_pend   <= 1'b0;
      r_rx_byte     <= 8'h00;
      r_rx_valid    <= 1'b0;
      r_tx_underrun <= 1'b0;
    end else begin
      r_rx_valid    <= 1'b0;
      r_tx_underrun <= w_load & ~r_hold_full;
      case (r_state)
        ST_IDLE: begin
          r_bit_cnt   <= 3'd0;
          r_load_pend <= 1'b0;
          if (w_ss_fall) begin
            r_state    <= ST_ACTIVE;
            r_tx_shift <= w_load_byte;
          end
        end
        ST_ACTIVE: begin
          if (w_ss_rise) begin
            // End of frame or abort: any partial RX/TX byte is dropped.
            r_state     <= ST_IDLE;
            r_bit_cnt   <= 3'd0;
            r_tx_shift  <= 8'h00;
            r_load_pend <= 1'b0;
          end else begin
            if (w_sclk_rise) begin
              r_rx_shift <= {r_rx_shift[5:0], w_mosi_s};
              r_bit_cnt  <= r_bit_cnt + 3'd1;
              if (r_bit_cnt == 3'd7) begin
                r_rx_byte   <= {r_rx_shift, w_mosi_s};
                r_rx_valid  <= 1'b1;
                r_load_pend <= 1'b1;
              end
            end
            if (w_sclk_fall) begin
              if (r_load_pend) begin
                r_tx_shift  <= w_load_byte;
                r_load_pend <= 1'b0;
              end else begin
                r_tx_shift <= {r_tx_shift[6:0], 1'b0};
              end
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

`ifdef SPI_SLAVE_MISO_OE_EN
  assign o_spi_miso    = r_tx_shift[7];
  assign o_spi_miso_oe = w_active;
`else
  assign o_spi_miso    = r_tx_shift[7] & w_active;
`endif

  assign o_tx_ready    = ~r_hold_full;
  assign o_rx_byte     = r_rx_byte;
  assign o_rx_valid    = r_rx_valid;
  assign o_tx_underrun = r_tx_underrun;
  assign o_busy        = w_active;

endmodule

// File: tb/tb_spi_slave_byte.sv
// tb_spi_slave_byte -- self-checking bench for spi_slave_byte.
// A bit-banged mode-0 master runs at f_clk = 16x f_sclk. A host process refills the
// holding register from a queue. A slot-level model predicts MISO bytes, underruns and ready.
module tb_spi_slave_byte;

  localparam int SYNC = 2;
  localparam int HALF = 8;

  logic       i_clk = 1'b0;
  logic       i_reset;
  logic       i_spi_sclk;
  logic       i_spi_ss_n;
  logic       i_spi_mosi;
  logic       o_spi_miso;
`ifdef SPI_SLAVE_MISO_OE_EN
  logic       o_spi_miso_oe;
`endif
  logic [7:0] i_tx_byte;
  logic       i_tx_valid;
  logic       o_tx_ready;
  logic [7:0] o_rx_byte;
  logic       o_rx_valid;
  logic       o_tx_underrun;
  logic       o_busy;

  spi_slave_byte #(.SYNC_STAGES(SYNC)) u_dut (
    .i_clk         (i_clk),
    .i_reset       (i_reset),
    .i_spi_sclk    (i_spi_sclk),
    .i_spi_ss_n    (i_spi_ss_n),
    .i_spi_mosi    (i_spi_mosi),
    .o_spi_miso    (o_spi_miso),
`ifdef SPI_SLAVE_MISO_OE_EN
    .o_spi_miso_oe (o_spi_miso_oe),
`endif
    .i_tx_byte     (i_tx_byte),
    .i_tx_valid    (i_tx_valid),
    .o_tx_ready    (o_tx_ready),
    .o_rx_byte     (o_rx_byte),
    .o_rx_valid    (o_rx_valid),
    .o_tx_underrun (o_tx_underrun),
    .o_busy        (o_busy)
  );

  initial forever #5 i_clk = ~i_clk;

  int n_cmp = 0;
  int n_err = 0;

  logic [7:0] host_q[$];
  logic [7:0] m_supply[$];
  logic [7:0] mst_tx[$];
  logic [7:0] mst_rx[$];
  logic [7:0] rx_seen[$];
  logic [7:0] exp_q[$];
  logic [7:0] m_hold;
  bit         m_full = 1'b0;
  bit         host_en = 1'b0;
  int         exp_ur;
  int         ur_seen = 0;
  int         fall_cnt = 0;
  logic       rdy_first;
  logic       busy_first;
  logic [7:0] last_rx = 8'h00;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic wclk(input int n);
    repeat (n) @(posedge i_clk);
    #1;
  endtask

  // Output monitor, sampled on the falling clock edge.
  initial forever begin
    @(negedge i_clk);
    if (o_rx_valid) rx_seen.push_back(o_rx_byte);
    if (o_tx_underrun) ur_seen++;
  end

  // Host side: offers the next queued byte whenever the holding register is empty.
  initial forever begin
    @(posedge i_clk);
    #1;
    if (host_en) begin
      if (i_tx_valid && !o_tx_ready) i_tx_valid = 1'b0;
      else if (!i_tx_valid && o_tx_ready && host_q.size() > 0) begin
        i_tx_byte  = host_q.pop_front();
        i_tx_valid = 1'b1;
      end
    end
  end

  task automatic supply(input logic [7:0] b);
    host_q.push_back(b);
    m_supply.push_back(b);
  endtask

  // Slot model: each started slot takes the holding byte if present, else 0x00 plus
  // an underrun; the host refills the empty register well within one byte time.
  task automatic model_frame(input int nslots);
    exp_q.delete();
    exp_ur = 0;
    for (int s = 0; s < nslots; s++) begin
      if (!m_full && m_supply.size() > 0) begin m_hold = m_supply.pop_front(); m_full = 1'b1; end
      if (m_full) begin exp_q.push_back(m_hold); m_full = 1'b0; end
      else begin exp_q.push_back(8'h00); exp_ur++; end
    end
    if (!m_full && m_supply.size() > 0) begin m_hold = m_supply.pop_front(); m_full = 1'b1; end
  endtask

  function automatic logic mosi_bit(input int i);
    logic [7:0] b;
    b = mst_tx[i/8];
    return b[7 - (i % 8)];
  endfunction

  // Mode-0 master. A full frame raises SS before the final SCLK fall; a shorter
  // nbits aborts the frame after the last fall.
  task automatic spi_frame(input int nbits);
    logic [7:0] sh;
    sh = 8'h00;
    i_spi_mosi = mosi_bit(0);
    i_spi_ss_n = 1'b0;
    wclk(HALF);
    for (int i = 0; i < nbits; i++) begin
      sh = {sh[6:0], o_spi_miso};
      i_spi_sclk = 1'b1;
      wclk(HALF);
      if (i == 0) begin rdy_first = o_tx_ready; busy_first = o_busy; end
      if ((i % 8) == 7) mst_rx.push_back(sh);
      if (i == nbits - 1 && (nbits % 8) == 0) begin
        i_spi_ss_n = 1'b1;
        wclk(HALF);
        i_spi_sclk = 1'b0;
        wclk(HALF);
      end else begin
        i_spi_sclk = 1'b0;
        fall_cnt++;
        if (i + 1 < nbits) i_spi_mosi = mosi_bit(i + 1);
        wclk(HALF);
        if (i == nbits - 1) begin
          i_spi_ss_n = 1'b1;
          wclk(HALF);
        end
      end
    end
    i_spi_mosi = 1'b0;
    wclk(2 * HALF);
  endtask

  task automatic compare_frame(input string tag, input int nbits, input int ur0);
    int nbytes;
    nbytes = nbits / 8;
    check({tag, "_busy_in_frame"}, busy_first, 1);
    if ((nbits % 8) == 0) begin
      check({tag, "_rx_count"}, rx_seen.size(), nbytes);
      if (rx_seen.size() == nbytes)
        for (int b = 0; b < nbytes; b++)
          check($sformatf("%s_rx%0d", tag, b), rx_seen[b], mst_tx[b]);
      for (int b = 0; b < mst_rx.size(); b++)
        check($sformatf("%s_miso%0d", tag, b), mst_rx[b], exp_q[b]);
      last_rx = mst_tx[nbytes - 1];
    end else begin
      check({tag, "_rx_count"}, rx_seen.size(), 0);
      check({tag, "_rx_hold"}, o_rx_byte, last_rx);
    end
    check({tag, "_underruns"}, ur_seen - ur0, exp_ur);
    check({tag, "_ready_after"}, o_tx_ready, !m_full);
    check({tag, "_busy_after"}, o_busy, 0);
    check({tag, "_miso_idle"}, o_spi_miso, 0);
  endtask

  task automatic run_frame(input string tag, input int nbits);
    int ur0;
    wclk(4);
    rx_seen.delete();
    mst_rx.delete();
    ur0 = ur_seen;
    model_frame((nbits + 7) / 8);
    fall_cnt = 0;
    spi_frame(nbits);
    compare_frame(tag, nbits, ur0);
    mst_tx.delete();
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_miso"}, o_spi_miso, 0);
    check({tag, "_rx_byte"}, o_rx_byte, 8'h00);
    check({tag, "_rx_valid"}, o_rx_valid, 0);
    check({tag, "_tx_ready"}, o_tx_ready, 1);
    check({tag, "_underrun"}, o_tx_underrun, 0);
    check({tag, "_busy"}, o_busy, 0);
`ifdef SPI_SLAVE_MISO_OE_EN
    check({tag, "_miso_oe"}, o_spi_miso_oe, 0);
`endif
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int ur0;
    int n;
    int nsup;
    i_reset    = 1'b0;
    i_spi_sclk = 1'b0;
    i_spi_ss_n = 1'b1;
    i_spi_mosi = 1'b0;
    i_tx_byte  = 8'h00;
    i_tx_valid = 1'b0;
    wclk(3);
    check_reset_values("reset");
    i_reset = 1'b1;
    host_en = 1'b1;
    wclk(4);

    // Preloaded A5 returned while 3C is received.
    supply(8'hA5);
    wclk(4);
    check("preload_ready_low", o_tx_ready, 0);
    mst_tx.push_back(8'h3C);
    run_frame("single", 8);
    check("single_ready_after_load", rdy_first, 1);

    // Three-byte frame with refills on each ready.
    supply(8'h11); supply(8'h22); supply(8'h33);
    mst_tx.push_back(8'h01); mst_tx.push_back(8'h80); mst_tx.push_back(8'hFF);
    run_frame("three", 24);

    // Empty holding register at frame start.
    mst_tx.push_back(8'h96);
    run_frame("empty", 8);

    // Handshake in the same cycle as a byte-boundary load with the register empty.
    host_en = 1'b0;
    wclk(4);
    rx_seen.delete();
    mst_rx.delete();
    ur0 = ur_seen;
    mst_tx.push_back(8'hC3); mst_tx.push_back(8'h69); mst_tx.push_back(8'h0F);
    exp_q.delete();
    exp_q.push_back(8'h00); exp_q.push_back(8'h00); exp_q.push_back(8'hE7);
    exp_ur = 2;
    fall_cnt = 0;
    fork
      spi_frame(24);
      begin
        wait (fall_cnt == 8);
        repeat (SYNC) @(posedge i_clk);
        #1;
        i_tx_byte  = 8'hE7;
        i_tx_valid = 1'b1;
        @(posedge i_clk);
        #1;
        i_tx_valid = 1'b0;
      end
    join
    compare_frame("race", 24, ur0);
    mst_tx.delete();
    host_en = 1'b1;

    // Abort after four rises; 5A arrives during the aborted frame and must survive.
    supply(8'h77); supply(8'h5A);
    mst_tx.push_back(8'hB4);
    run_frame("abort", 4);
    mst_tx.push_back(8'h4B);
    run_frame("after_abort", 8);

    // Randomised frames, some with too few host bytes.
    for (int f = 0; f < 8; f++) begin
      n = $urandom_range(1, 3);
      nsup = $urandom_range(0, n);
      for (int i = 0; i < n; i++) mst_tx.push_back(8'($urandom_range(0, 255)));
      for (int i = 0; i < nsup; i++) supply(8'($urandom_range(0, 255)));
      run_frame($sformatf("rnd%0d", f), 8 * n);
    end

    // Reset mid-frame, then SCLK activity while SS is still low must be ignored.
    supply(8'hDD);
    wclk(4);
    i_spi_ss_n = 1'b0;
    wclk(HALF);
    for (int i = 0; i < 3; i++) begin
      i_spi_sclk = 1'b1; wclk(HALF);
      i_spi_sclk = 1'b0; wclk(HALF);
    end
    host_en = 1'b0;
    i_tx_valid = 1'b0;
    host_q.delete();
    m_supply.delete();
    m_full = 1'b0;
    i_reset = 1'b0;
    #2;
    check_reset_values("midreset");
    wclk(2);
    i_reset = 1'b1;
    last_rx = 8'h00;
    rx_seen.delete();
    wclk(HALF);
    for (int i = 0; i < 8; i++) begin
      i_spi_mosi = i[0];
      i_spi_sclk = 1'b1; wclk(HALF);
      i_spi_sclk = 1'b0; wclk(HALF);
    end
    check("stale_ss_busy", o_busy, 0);
    check("stale_ss_rx_count", rx_seen.size(), 0);
    i_spi_ss_n = 1'b1;
    wclk(2 * HALF);
    host_en = 1'b1;
    supply(8'h6E);
    mst_tx.push_back(8'($urandom_range(0, 255)));
    run_frame("post_reset", 8);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
